bsg_axil_cmd_master: RTL



---
 rtl/bsg_axil_cmd_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bsg_axil_cmd_master.sv
// Command-level AXI4-Lite master: whole read/write commands in, AXI channels out,
// responses returned through a single registered entry with a sticky hung-slave flag.
module bsg_axil_cmd_master #(
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int max_outstanding_p = 4,
  parameter int strict_order_p    = 0,
  parameter int timeout_p         = 1024
) (
  input  logic                        aclk_i,
  input  logic                        aresetn_i,

  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_w_i,
  input  logic [addr_width_p-1:0]     cmd_addr_i,
  input  logic [data_width_p-1:0]     cmd_data_i,
  input  logic [data_width_p/8-1:0]   cmd_wstrb_i,

  output logic                        resp_v_o,
  input  logic                        resp_yumi_i,
  output logic                        resp_w_o,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic [1:0]                  resp_code_o,
  output logic                        timeout_o,

  output logic [addr_width_p-1:0]     awaddr_o,
  output logic [2:0]                  awprot_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [data_width_p-1:0]     wdata_o,
  output logic [data_width_p/8-1:0]   wstrb_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  input  logic [1:0]                  bresp_i,
  input  logic                        bvalid_i,
  output logic                        bready_o,
  output logic [addr_width_p-1:0]     araddr_o,
  output logic [2:0]                  arprot_o,
  output logic                        arvalid_o,
  input  logic                        arready_i,
  input  logic [data_width_p-1:0]     rdata_i,
  input  logic [1:0]                  rresp_i,
  input  logic                        rvalid_i,
  output logic                        rready_o
);

  localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
  localparam int strb_w_lp = data_width_p / 8;
  localparam int tcnt_w_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [cnt_w_lp-1:0]  max_lp    = cnt_w_lp'(max_outstanding_p);
  localparam logic [tcnt_w_lp-1:0] tmax_lp   = tcnt_w_lp'(timeout_p);
  localparam bit                   strict_lp = (strict_order_p != 0);
  localparam bit                   to_en_lp  = (timeout_p > 0);

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE} state_e;

  state_e r_state, w_state_n;

  logic [cnt_w_lp-1:0]     r_wcnt, r_rcnt;
  logic [tcnt_w_lp-1:0]    r_tcnt;
  logic                    r_timeout;
  logic                    r_awvalid, r_wvalid, r_arvalid;
  logic [addr_width_p-1:0] r_awaddr, r_araddr;
  logic [data_width_p-1:0] r_wdata;
  logic [strb_w_lp-1:0]    r_wstrb;
  logic                    r_resp_v, r_resp_w;
  logic [data_width_p-1:0] r_resp_data;
  logic [1:0]              r_resp_code;

  logic w_dir_ok, w_ord_ok, w_acc, w_winc, w_rinc;
  logic w_b_hs, w_r_hs, w_b_ok, w_r_ok;
  logic w_aw_done, w_w_done, w_busy, w_any_hs;

  // Ready is combinational from cmd_w_i: the direction picks which counter gates it.
  assign w_dir_ok    = cmd_w_i ? (r_wcnt < max_lp) : (r_rcnt < max_lp);
  assign w_ord_ok    = !strict_lp || (cmd_w_i ? (r_rcnt == '0) : (r_wcnt == '0));
  assign cmd_ready_o = aresetn_i && (r_state == IDLE) && w_dir_ok && w_ord_ok;

  assign w_acc  = cmd_v_i & cmd_ready_o;
  assign w_winc = w_acc & cmd_w_i;
  assign w_rinc = w_acc & ~cmd_w_i;

  assign bready_o = ~r_resp_v;
  assign rready_o = ~r_resp_v & ~bvalid_i;
  assign w_b_hs   = bvalid_i & bready_o;
  assign w_r_hs   = rvalid_i & rready_o;
  // A response with nothing outstanding in its direction is dropped.
  assign w_b_ok   = w_b_hs & (r_wcnt != '0);
  assign w_r_ok   = w_r_hs & (r_rcnt != '0);

  assign w_aw_done = ~r_awvalid | awready_i;
  assign w_w_done  = ~r_wvalid | wready_i;

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) r_state <= IDLE;
    else            r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:     if (w_acc) w_state_n = cmd_w_i ? WR_ISSUE : RD_ISSUE;
      WR_ISSUE: if (w_aw_done && w_w_done) w_state_n = IDLE;
      RD_ISSUE: if (arready_i) w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_winc && !w_b_ok)      r_wcnt <= r_wcnt + cnt_w_lp'(1);
      else if (!w_winc && w_b_ok) r_wcnt <= r_wcnt - cnt_w_lp'(1);
      if (w_rinc && !w_r_ok)      r_rcnt <= r_rcnt + cnt_w_lp'(1);
      else if (!w_rinc && w_r_ok) r_rcnt <= r_rcnt - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
    end else begin
      if (w_winc) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= cmd_addr_i;
        r_wdata   <= cmd_data_i;
        r_wstrb   <= cmd_wstrb_i;
      end else begin
        if (awready_i) r_awvalid <= 1'b0;
        if (wready_i)  r_wvalid  <= 1'b0;
      end
      if (w_rinc) begin
        r_arvalid <= 1'b1;
        r_araddr  <= cmd_addr_i;
      end else if (arready_i) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  // Single response entry; B has priority over R through rready_o.
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      r_resp_v    <= 1'b0;
      r_resp_w    <= 1'b0;
      r_resp_data <= '0;
      r_resp_code <= '0;
    end else if (w_b_ok) begin
      r_resp_v    <= 1'b1;
      r_resp_w    <= 1'b1;
      r_resp_data <= '0;
      r_resp_code <= bresp_i;
    end else if (w_r_ok) begin
      r_resp_v    <= 1'b1;
      r_resp_w    <= 1'b0;
      r_resp_data <= rdata_i;
      r_resp_code <= rresp_i;
    end else if (resp_yumi_i) begin
      r_resp_v    <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (aresetn_i) begin
      assert (!(w_b_hs && (r_wcnt == '0)));
      assert (!(w_r_hs && (r_rcnt == '0)));
    end
  end

  assign w_busy   = (r_state != IDLE) || (r_wcnt != '0) || (r_rcnt != '0);
  assign w_any_hs = (r_awvalid & awready_i) | (r_wvalid & wready_i) |
                    (r_arvalid & arready_i) | w_b_hs | w_r_hs;

  // Stall counter saturates at the limit; the flag is sticky until reset.
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (to_en_lp && (r_tcnt == tmax_lp)) r_timeout <= 1'b1;
      if (w_any_hs || !w_busy)             r_tcnt <= '0;
      else if (r_tcnt != tmax_lp)          r_tcnt <= r_tcnt + tcnt_w_lp'(1);
    end
  end

  assign awaddr_o    = r_awaddr;
  assign awprot_o    = 3'b000;
  assign awvalid_o   = r_awvalid;
  assign wdata_o     = r_wdata;
  assign wstrb_o     = r_wstrb;
  assign wvalid_o    = r_wvalid;
  assign araddr_o    = r_araddr;
  assign arprot_o    = 3'b000;
  assign arvalid_o   = r_arvalid;
  assign resp_v_o    = r_resp_v;
  assign resp_w_o    = r_resp_w;
  assign resp_data_o = r_resp_data;
  assign resp_code_o = r_resp_code;
  assign timeout_o   = r_timeout;

endmodule
